// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with count, threshold flags, sticky errors and flush; define UART_SYNC_FIFO_FWFT_EN for first-word-fall-through
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 2**ADDR_WIDTH-2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);
  localparam int DEPTH_I = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH = DEPTH_I[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE = AE_THRESH[ADDR_WIDTH:0];
  logic [DATA_WIDTH-1:0] mem [DEPTH_I];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic rd_acc, wr_acc;
  assign empty = count == '0;
  assign full = count == DEPTH;
  assign almost_empty = count <= AE;
  assign almost_full = count >= AF;
  assign rd_acc = rd_en & ~empty & ~flush;
  assign wr_acc = wr_en & ~flush & (~full | rd_acc);
  // storage is written only on accepted writes; contents need no reset
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= din;
  // pointers and occupancy; flush clears all three
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_WIDTH'(wr_acc);
      rd_ptr <= rd_ptr + ADDR_WIDTH'(rd_acc);
      count <= count + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_acc);
    end
  // sticky error flags; a new error coinciding with clr_err keeps the flag set
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= (overflow & ~clr_err) | (wr_en & ~wr_acc & ~flush);
      underflow <= (underflow & ~clr_err) | (rd_en & ~rd_acc & ~flush);
    end
`ifdef UART_SYNC_FIFO_FWFT_EN
  assign dout = empty ? '0 : mem[rd_ptr];
`else
  // registered read: head word loads on an accepted read, otherwise held
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dout <= '0;
    else if (rd_acc) dout <= mem[rd_ptr];
`endif
endmodule

// File: tb/tb_uart_sync_fifo.sv
// tb_uart_sync_fifo: randomized and directed checks of uart_sync_fifo against a queue-based model
module tb_uart_sync_fifo;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] din = '0, dout;
  logic [4:0] count;
  logic empty, full, almost_empty, almost_full, overflow, underflow;
  int checks = 0, fails = 0;
  logic [7:0] q[$];
  logic [7:0] m_dout = '0;
  logic m_ovf = 1'b0, m_udf = 1'b0;
  logic [18:0] obs;

  uart_sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .count(count), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .overflow(overflow), .underflow(underflow), .clr_err(clr_err));

  always #5 clk = ~clk;
  assign obs = {dout, count, empty, full, almost_empty, almost_full, overflow, underflow};

  function automatic logic [18:0] exp_vec();
    int n = q.size();
    logic [7:0] d;
`ifdef UART_SYNC_FIFO_FWFT_EN
    d = (n > 0) ? q[0] : 8'h00;
`else
    d = m_dout;
`endif
    return {d, 5'(n), n == 0, n == 16, n <= 2, n >= 14, m_ovf, m_udf};
  endfunction

  function automatic void model_reset();
    q.delete();
    m_dout = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endfunction

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f, input logic c);
    int n = q.size();
    logic racc, wacc;
    wr_en = w; din = d; rd_en = r; flush = f; clr_err = c;
    racc = r && !f && n > 0;
    wacc = w && !f && (n < 16 || racc);
    if (f) q.delete();
    if (racc) m_dout = q.pop_front();
    if (wacc) q.push_back(d);
    m_ovf = (m_ovf && !c) || (w && !wacc && !f);
    m_udf = (m_udf && !c) || (r && !racc && !f);
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== exp_vec() || count !== 5'd0 || empty !== 1'b1 || dout !== 8'h00) begin
      fails++;
      $display("FAIL reset: got %h want %h", obs, exp_vec());
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] v[3] = '{8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) step(1'b1, v[i], 1'b0, 1'b0, 1'b0);
      else step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec() || (i >= 3 && dout !== v[i-3])) begin
        fails++;
        $display("FAIL basic step %0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec() || almost_empty !== (i < 2) || almost_full !== (i >= 13) || full !== (i >= 15)) begin
        fails++;
        $display("FAIL fill write %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL fill read %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_vec() || count !== 5'd16 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL full_rw: got %h want %h", obs, exp_vec());
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec() || (i == 15 && dout !== 8'h55)) begin
        fails++;
        $display("FAIL full_rw drain %0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_vec() || underflow !== 1'b1) begin
      fails++;
      $display("FAIL underflow set: got %h want %h", obs, exp_vec());
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== exp_vec() || underflow !== 1'b0) begin
      fails++;
      $display("FAIL underflow clear: got %h want %h", obs, exp_vec());
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    checks++;
    if (obs !== exp_vec() || underflow !== 1'b1) begin
      fails++;
      $display("FAIL underflow set_wins: got %h want %h", obs, exp_vec());
    end
    step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
    checks++;
    if (obs !== exp_vec() || count !== 5'd1) begin
      fails++;
      $display("FAIL underflow rd_wr_empty: got %h want %h", obs, exp_vec());
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_vec() || count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      fails++;
      $display("FAIL flush: got %h want %h", obs, exp_vec());
    end
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_vec() || dout !== 8'h77) begin
      fails++;
      $display("FAIL flush reuse: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    int wp;
    for (int i = 0; i < 400; i++) begin
      wp = ((i / 40) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < 50,
           $urandom_range(0, 29) == 0, $urandom_range(0, 15) == 0);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== exp_vec() || count !== 5'd0 || dout !== 8'h00) begin
      fails++;
      $display("FAIL midreset async: got %h want %h", obs, exp_vec());
    end
    wr_en = 1'b1; din = 8'h99;
    @(posedge clk); #1;
    wr_en = 1'b0;
    checks++;
    if (obs !== exp_vec()) begin
      fails++;
      $display("FAIL midreset hold: got %h want %h", obs, exp_vec());
    end
    rst_n = 1'b1;
    step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_vec()) begin
      fails++;
      $display("FAIL midreset resume: got %h want %h", obs, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_full_rw();
    test_underflow();
    test_flush();
    test_random();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule

// File: doc/uart_sync_fifo.md
# uart_sync_fifo

Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It is the next-generation buffer for the UART TX and RX data paths, sitting between the byte-level UART engines and the host bus interface. It replaces the fixed-flag FIFO in that role.

## Interface
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 4: address bits; DEPTH = 2**ADDR_WIDTH entries.
- AF_THRESH, 2**ADDR_WIDTH-2: almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of contents; highest priority.
- wr_en  in  1  write request.
- din  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- dout  out  DATA_WIDTH  read data.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_THRESH.
- almost_full  out  1  count >= AF_THRESH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clr_err  in  1  clears overflow and underflow.

## Operation
- Storage: DEPTH x DATA_WIDTH array; write and read pointers are ADDR_WIDTH bits wide and wrap naturally from DEPTH-1 to 0.
- Read accept: rd_acc = rd_en & !empty & !flush.
- Write accept: wr_acc = wr_en & !flush & (!full | rd_acc). A write while full is accepted only when a read is accepted in the same cycle.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
- Flush: wr_ptr, rd_ptr and count go to 0. Any wr_en/rd_en in the same cycle is ignored and does not set the error flags. dout is held; array contents are don't-care.
- overflow is set by wr_en & !wr_acc & !flush. underflow is set by rd_en & !rd_acc & !flush. Both stay set until clr_err.
- If clr_err coincides with a new error event, the flag remains set; set wins.
- Read of empty FIFO with a simultaneous write: the read is rejected and sets underflow; the write is accepted.
- Reset values: dout = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0, both pointers = 0.
- Reset asserted mid-operation immediately forces the reset values; stored data is lost.

## Timing
- All flags are decoded from registered count and reflect accepted operations one edge after acceptance.
- Write accepted at edge N: empty deasserts after edge N.
- Standard mode: read accepted at edge N loads dout with the head word at edge N; 1-cycle read latency. dout holds its value when no read is accepted.
- Simultaneous read and write on a non-empty FIFO: count, full and almost flags are unchanged.
- Error flags assert the edge after the offending request.

## Configuration
- UART_SYNC_FIFO_FWFT_EN defined: first-word-fall-through. dout continuously presents mem[rd_ptr] whenever !empty. A word written at edge N appears on dout after edge N, together with empty = 0. rd_en acknowledges (pops) the presented word, and the next word appears after that edge. dout is 0 while empty.
- UART_SYNC_FIFO_FWFT_EN undefined: standard registered read as described under Timing.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=4, AF_THRESH=14, AE_THRESH=2.
- Reset release, then write AA, BB, CC on 3 consecutive cycles, then read 3 -> dout AA, BB, CC (standard mode, 1-cycle latency); count 3 -> 0; empty re-asserts after the last read.
- Write 16 words 00..0F -> almost_empty deasserts when count reaches 3; almost_full asserts at count 14; full asserts at 16. A 17th write sets overflow with count held at 16. Reading all 16 -> 00..0F, wrapping correctly.
- Full FIFO with simultaneous wr_en (din 55) and rd_en -> both accepted; count stays 16; overflow not set; 55 is read out last.
- Empty FIFO with rd_en -> underflow = 1, count 0. clr_err pulse -> underflow = 0. clr_err together with another empty read -> underflow stays 1.
- Count 5, then flush together with wr_en -> count 0, empty 1, no error flags; a subsequent write/read returns the new data.
- FWFT build: write 3C to empty FIFO -> dout = 3C after the write edge with no rd_en. rd_en pulse -> empty = 1, dout = 0. Assert rst_n low mid-stream -> all outputs return to their reset values immediately.
